// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: 2-bit branch counter encodings and predictor defaults.
package pipeline_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int BHT_ENTRIES_DEFAULT = 16;
    localparam int ALIGN_SHIFT         = 2;

endpackage

// File: rtl/sat_counter2.sv
// One 2-bit saturating up/down counter with a parameterised asynchronous reset value.
module sat_counter2
    import pipeline_pkg::*;
#(
    parameter logic [1:0] INIT = ST
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en,
    input  logic       taken,
    output logic [1:0] state
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= INIT;
        end else if (en) begin
            if (taken) begin
                if (state != ST) state <= state + 2'd1;
            end else begin
                if (state != SNT) state <= state - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor (BHT of 2-bit counters) for the 5-stage pipeline.
// Define BRANCH_PREDICTOR_STATS_EN to build the resolved-branch / misprediction counters.
module branch_predictor
    import pipeline_pkg::*;
#(
    parameter int         BHT_ENTRIES = BHT_ENTRIES_DEFAULT,
    parameter logic [1:0] INIT_STATE  = ST
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_instr_id,
    input  logic [31:0] pc_id,
    output logic        branch_pred_id,
    input  logic        branch_instr_exe,
    input  logic [31:0] pc_exe,
    input  logic        is_zero,
    input  logic        branch_pred_exe,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int IDX_W  = $clog2(BHT_ENTRIES);
    // A single-entry table has no index bits, but the index signal still needs a width.
    localparam int IDX_WS = (IDX_W == 0) ? 1 : IDX_W;

    function automatic logic [IDX_WS-1:0] idx_of(input logic [31:0] pc);
        logic [31:0] word;
        word = (pc >> ALIGN_SHIFT) & 32'(BHT_ENTRIES - 1);
        return word[IDX_WS-1:0];
    endfunction

    logic [IDX_WS-1:0] idx_id;
    logic [IDX_WS-1:0] idx_exe;
    logic [1:0]        bht [BHT_ENTRIES];

    assign idx_id  = idx_of(pc_id);
    assign idx_exe = idx_of(pc_exe);

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        sat_counter2 #(
            .INIT (INIT_STATE)
        ) u_ctr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en    (branch_instr_exe && (idx_exe == IDX_WS'(i))),
            .taken (is_zero),
            .state (bht[i])
        );
    end

    // Lookup reads the pre-edge table, so a same-cycle update to the same entry is not bypassed.
    assign branch_pred_id = branch_instr_id & bht[idx_id][1];

`ifdef BRANCH_PREDICTOR_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else if (branch_instr_exe) begin
            if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
            if ((branch_pred_exe != is_zero) && (mispred_cnt != 32'hFFFF_FFFF))
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{pc_id, pc_exe};
`else
    assign branch_cnt  = 32'd0;
    assign mispred_cnt = 32'd0;

    logic unused_inputs;
    assign unused_inputs = ^{pc_id, pc_exe, branch_pred_exe};
`endif

endmodule
